// File: rtl/cmd_pkg.sv
// Shared types and constants for the command frame parser.
package cmd_pkg;

    typedef enum logic [2:0] {
        HUNT,
        CMD,
        ADDR,
        DATA,
        CSUM,
        EMIT
    } parser_state_t;

    localparam logic [1:0] CMD_READ  = 2'd0;
    localparam logic [1:0] CMD_WRITE = 2'd1;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/frame_timer.sv
// Inter-byte idle timer: counts idle cycles while a frame is open and
// flags when the allowed gap has been used up.
module frame_timer #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    // Restart on every consumed byte or outside a frame, otherwise count up to the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run && (count != LAST)) begin
            count <= count + CW'(1);
        end
    end

    assign expired = run && (count == LAST);

endmodule

// File: rtl/cmd_frame_parser.sv
// Parses SYNC/CMD/ADDR/DATA/CSUM byte frames from a byte FIFO and writes
// decoded commands into a command FIFO, flagging framing errors.
module cmd_frame_parser
    import cmd_pkg::*;
#(
    parameter int          ADDR_BYTES     = 2,
    parameter int          DATA_BYTES     = 4,
    parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter int          TIMEOUT_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    byte_fifo_valid,
    input  logic [7:0]              byte_fifo_data,
    output logic                    byte_fifo_rd_en,
    input  logic                    cmd_fifo_full,
    output logic                    cmd_fifo_wr_en,
    output logic [1:0]              cmd_type,
    output logic [8*ADDR_BYTES-1:0] cmd_addr,
    output logic [8*DATA_BYTES-1:0] cmd_data,
    output logic                    err_checksum,
    output logic                    err_timeout,
    output logic                    err_bad_cmd
);

    parser_state_t state;
    parser_state_t next_state;

    logic [1:0] byte_cnt;
    logic [7:0] csum;
    logic       consume;
    logic       in_frame;
    logic       timer_expired;
    logic       addr_last;
    logic       data_last;
    logic       next_err_checksum;
    logic       next_err_timeout;
    logic       next_err_bad_cmd;

    logic [8*ADDR_BYTES-1:0] addr_shifted;
    logic [8*DATA_BYTES-1:0] data_shifted;

    // The FIFO is never popped while a finished command waits for space, nor in reset.
    assign byte_fifo_rd_en = rst_n && byte_fifo_valid && (state != EMIT);
    assign consume         = byte_fifo_rd_en;
    assign cmd_fifo_wr_en  = (state == EMIT) && !cmd_fifo_full;

    assign in_frame  = (state == CMD) || (state == ADDR) || (state == DATA) || (state == CSUM);
    assign addr_last = (byte_cnt == 2'(ADDR_BYTES - 1));
    assign data_last = (byte_cnt == 2'(DATA_BYTES - 1));

    frame_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (consume || !in_frame),
        .run    (in_frame),
        .expired(timer_expired)
    );

    // Field registers shift left one byte, new byte enters at the bottom (MSB-first on the wire).
    always_comb begin
        addr_shifted       = cmd_addr << 8;
        addr_shifted[7:0]  = byte_fifo_data;
        data_shifted       = cmd_data << 8;
        data_shifted[7:0]  = byte_fifo_data;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HUNT;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and error decisions; a consumed byte always takes priority over a timeout.
    always_comb begin
        next_state        = state;
        next_err_checksum = 1'b0;
        next_err_timeout  = 1'b0;
        next_err_bad_cmd  = 1'b0;
        unique case (state)
            HUNT: begin
                if (consume && (byte_fifo_data == SYNC_BYTE)) begin
                    next_state = CMD;
                end
            end
            CMD: begin
                if (consume) begin
                    if (byte_fifo_data[7:2] != 6'd0) begin
                        next_state       = HUNT;
                        next_err_bad_cmd = 1'b1;
                    end else begin
                        next_state = ADDR;
                    end
                end else if (timer_expired) begin
                    next_state       = HUNT;
                    next_err_timeout = 1'b1;
                end
            end
            ADDR: begin
                if (consume) begin
                    if (addr_last) begin
                        next_state = DATA;
                    end
                end else if (timer_expired) begin
                    next_state       = HUNT;
                    next_err_timeout = 1'b1;
                end
            end
            DATA: begin
                if (consume) begin
                    if (data_last) begin
                        next_state = CSUM;
                    end
                end else if (timer_expired) begin
                    next_state       = HUNT;
                    next_err_timeout = 1'b1;
                end
            end
            CSUM: begin
                if (consume) begin
                    if (byte_fifo_data == csum) begin
                        next_state = EMIT;
                    end else begin
                        next_state        = HUNT;
                        next_err_checksum = 1'b1;
                    end
                end else if (timer_expired) begin
                    next_state       = HUNT;
                    next_err_timeout = 1'b1;
                end
            end
            EMIT: begin
                if (!cmd_fifo_full) begin
                    next_state = HUNT;
                end
            end
            default: begin
                next_state = HUNT;
            end
        endcase
    end

    // Datapath: field capture, running XOR, byte counter and registered error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt     <= 2'd0;
            csum         <= 8'd0;
            cmd_type     <= 2'd0;
            cmd_addr     <= '0;
            cmd_data     <= '0;
            err_checksum <= 1'b0;
            err_timeout  <= 1'b0;
            err_bad_cmd  <= 1'b0;
        end else begin
            err_checksum <= next_err_checksum;
            err_timeout  <= next_err_timeout;
            err_bad_cmd  <= next_err_bad_cmd;
            if (consume) begin
                case (state)
                    CMD: begin
                        if (byte_fifo_data[7:2] == 6'd0) begin
                            cmd_type <= byte_fifo_data[1:0];
                            csum     <= byte_fifo_data;
                            byte_cnt <= 2'd0;
                        end
                    end
                    ADDR: begin
                        cmd_addr <= addr_shifted;
                        csum     <= csum ^ byte_fifo_data;
                        byte_cnt <= addr_last ? 2'd0 : byte_cnt + 2'd1;
                    end
                    DATA: begin
                        cmd_data <= data_shifted;
                        csum     <= csum ^ byte_fifo_data;
                        byte_cnt <= data_last ? 2'd0 : byte_cnt + 2'd1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/cmd_frame_parser.md
CMD_FRAME_PARSER -- requirements
Module: cmd_frame_parser

Interface
REQ-001 Parameter ADDR_BYTES, default 2, address field length in bytes (1-4).
REQ-002 Parameter DATA_BYTES, default 4, data field length in bytes (1-4).
REQ-003 Parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-004 Parameter TIMEOUT_CYCLES, default 1000, maximum idle clocks between bytes inside a frame (>=2).
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 byte_fifo_valid  input  1  byte FIFO not empty.
REQ-008 byte_fifo_data  input  8  byte FIFO head.
REQ-009 byte_fifo_rd_en  output  1  pop request; a byte is consumed when valid and rd_en are both high.
REQ-010 cmd_fifo_full  input  1  command FIFO full, provides backpressure.
REQ-011 cmd_fifo_wr_en  output  1  command write strobe.
REQ-012 cmd_type  output  2  command type of the emitted frame.
REQ-013 cmd_addr  output  8*ADDR_BYTES  address of the emitted frame.
REQ-014 cmd_data  output  8*DATA_BYTES  data of the emitted frame.
REQ-015 err_checksum, err_timeout, err_bad_cmd  output  1 each  single-cycle error pulses.

Function
REQ-016 Frame format SHALL be: SYNC_BYTE, CMD, ADDR (MSB byte first), DATA (MSB byte first), CSUM. CSUM is the XOR of CMD through the last DATA byte.
REQ-017 The FSM SHALL have the states HUNT, CMD, ADDR, DATA, CSUM and EMIT.
REQ-018 HUNT: each consumed byte SHALL be discarded unless it equals SYNC_BYTE; a SYNC_BYTE moves the FSM to CMD.
REQ-019 CMD: if byte[7:2] is nonzero, the FSM SHALL pulse err_bad_cmd and return to HUNT. Otherwise it SHALL latch byte[1:0], seed the running XOR with the byte, and go to ADDR.
REQ-020 ADDR and DATA SHALL shift bytes into their field registers and fold each byte into the XOR. A byte counter SHALL advance to DATA after ADDR_BYTES bytes and to CSUM after DATA_BYTES bytes.
REQ-021 CSUM: on a match the FSM SHALL go to EMIT. On a mismatch it SHALL pulse err_checksum, go to HUNT, and make no write.
REQ-022 byte_fifo_rd_en SHALL equal byte_fifo_valid in every state except EMIT, where it SHALL be 0.
REQ-023 EMIT: cmd_fifo_wr_en SHALL be high exactly when cmd_fifo_full is low, and the FSM SHALL go to HUNT on that cycle. While full is high, the FSM SHALL hold in EMIT indefinitely, outputs stable, with no timeout.
REQ-024 Minimum latency SHALL be 1 cycle: wr_en asserts the clock after the CSUM byte is consumed.
REQ-025 cmd_type, cmd_addr and cmd_data SHALL be registered and remain stable from EMIT entry until the next frame's CMD byte is latched.
REQ-026 The timeout counter SHALL clear on every consumed byte and count while in CMD, ADDR, DATA or CSUM with no byte consumed.
REQ-027 When the counter reaches TIMEOUT_CYCLES-1, the FSM SHALL pulse err_timeout and go to HUNT.
REQ-028 If a byte is consumed on the same cycle the counter reaches TIMEOUT_CYCLES-1, the byte SHALL win and no timeout SHALL occur.
REQ-029 A SYNC_BYTE value received inside a frame SHALL be treated as ordinary payload (no resync).
REQ-030 At most one error pulse SHALL assert per cycle, and no error SHALL coincide with wr_en.

Reset
REQ-031 While rst_n is low, state SHALL be HUNT, and all counters, the XOR and the field registers SHALL be 0.
REQ-032 While rst_n is low, byte_fifo_rd_en, cmd_fifo_wr_en and all err_* outputs SHALL be 0.
REQ-033 Reset asserted mid-frame or in EMIT SHALL discard the partial frame with no write.

Structure
REQ-034 cmd_pkg SHALL hold the state enum, the CMD_READ/CMD_WRITE 2-bit encodings and the default SYNC_BYTE constant.
REQ-035 Sub-module frame_timer SHALL implement the timeout counter, with ports clear, run and expired.

Verification (default parameters)
REQ-036 Bench SHALL send A5 01 12 34 DE AD BE EF 05 -> one wr_en pulse with type=1, addr=16'h1234, data=32'hDEADBEEF, and no errors.
REQ-037 Bench SHALL send the same frame with CSUM=06 -> err_checksum pulse, no wr_en, FSM in HUNT.
REQ-038 Bench SHALL send 00 FF A5 then a valid frame body -> the leading bytes are discarded and exactly one correct command is emitted.
REQ-039 Bench SHALL send A5 01 12, then stall 1000 cycles -> err_timeout pulse, HUNT. A following valid frame is then accepted.
REQ-040 Bench SHALL hold cmd_fifo_full high for 20 cycles after a valid frame -> rd_en low and outputs stable throughout; wr_en on the first cycle full drops.
REQ-041 Bench SHALL send A5 04 -> err_bad_cmd pulse, HUNT.
